// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: IMEM read port plus the decode-side valid/ready port.
// The fetch unit uses the master modport; memory/decode/execute use slave.
interface instr_fetch_if #(
  parameter int BITS   = 32,
  parameter int ADDR_W = 32
);
  logic              ImemReq;
  logic [ADDR_W-1:0] ImemAddr;
  logic [BITS-1:0]   ImemData;
  logic [BITS-1:0]   Instruction;
  logic [ADDR_W-1:0] InstrPC;
  logic              InstrValid;
  logic              InstrReady;
  logic              Redirect;
  logic [ADDR_W-1:0] RedirectPC;
  logic              Halted;

  modport master (
    output ImemReq, ImemAddr, Instruction, InstrPC, InstrValid, Halted,
    input  ImemData, InstrReady, Redirect, RedirectPC
  );

  modport slave (
    input  ImemReq, ImemAddr, Instruction, InstrPC, InstrValid, Halted,
    output ImemData, InstrReady, Redirect, RedirectPC
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues reads to a synchronous
// IMEM (data one cycle after the strobe), buffers responses with their PC in
// a small prefetch FIFO and hands them to decode over valid/ready.
// Optional feature macro: FETCH_HALT_EN -- when defined, accepting the word
// HALT_INSTR parks the unit in a HALT state until a Redirect arrives.
module instr_fetch_unit #(
  parameter int                BITS       = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                DEPTH      = 2,
  parameter logic [BITS-1:0]   HALT_INSTR = BITS'(32'h0000_0073)
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  localparam logic HALT_EN = 1'b1;
`else
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic HALT_EN = 1'b0;
`endif

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] req_pc_r;     // address of the read whose data arrives this cycle
  logic              inflight_r;   // a read was issued last cycle
  logic [BITS-1:0]   mem_data_r [DEPTH];
  logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              flush_s;
  logic              head_is_halt_s;
  logic              halt_take_s;
  logic [CNT_W:0]    occ_s;
  logic [CNT_W:0]    limit_s;
  logic [ADDR_W-1:0] redirect_pc_s;

  // Pointer advance helper; DEPTH is a power of two so the pointer wraps for free.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // Handshake, flush and issue decisions for the current cycle.
  always_comb begin
    redirect_pc_s  = bus.RedirectPC & ~(ADDR_W'(3));
    pop_s          = (count_r != CNT_W'(0)) & bus.InstrReady & ~bus.Redirect;
    head_is_halt_s = (mem_data_r[rd_ptr_r] == HALT_INSTR);
    halt_take_s    = HALT_EN & (state_r == RUN) & pop_s & head_is_halt_s;
    // Redirect and halt both discard the FIFO and the response arriving now.
    flush_s        = bus.Redirect | halt_take_s;
    push_s         = inflight_r & ~flush_s & (state_r == RUN);
    // Slots committed = buffered + in flight. A pop this cycle frees a slot
    // before the new read's data can land, which keeps 1 instr/cycle streaming.
    occ_s          = {1'b0, count_r} + {CNT_W'(0), inflight_r};
    limit_s        = DEPTH_L + {CNT_W'(0), pop_s};
    if ((state_r == RUN) && !flush_s && (occ_s < limit_s)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state logic: IDLE lasts one cycle, HALT is left only through Redirect.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: state_s = RUN;
      RUN: begin
`ifdef FETCH_HALT_EN
        if (halt_take_s) begin
          state_s = HALT;
        end else begin
          state_s = RUN;
        end
`else
        state_s = RUN;
`endif
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        if (bus.Redirect) begin
          state_s = RUN;
        end else begin
          state_s = HALT;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // PC, in-flight tracking and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      req_pc_r   <= RESET_PC;
      inflight_r <= 1'b0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        req_pc_r <= pc_r;
      end
      if (bus.Redirect) begin
        pc_r <= redirect_pc_s;
      end else if (issue_s) begin
        pc_r <= pc_r + ADDR_W'(4);
      end
      if (flush_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= ptr_inc(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // FIFO storage: capture the IMEM word together with the PC it was read from.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= '0;
        mem_pc_r[i]   <= '0;
      end
    end else if (push_s) begin
      mem_data_r[wr_ptr_r] <= bus.ImemData;
      mem_pc_r[wr_ptr_r]   <= req_pc_r;
    end
  end

  assign bus.ImemReq     = issue_s;
  assign bus.ImemAddr    = pc_r;
  assign bus.Instruction = mem_data_r[rd_ptr_r];
  assign bus.InstrPC     = mem_pc_r[rd_ptr_r];
  assign bus.InstrValid  = (count_r != CNT_W'(0));
`ifdef FETCH_HALT_EN
  assign bus.Halted      = (state_r == HALT);
`else
  assign bus.Halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes the expected
// (PC, word) stream, a negedge monitor checks every decode transfer.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic halt_prog;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  time  xfer_t[$];

  instr_fetch_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMEM contents: addr ^ A5A5_0000, optionally with a halt word at 0x10.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (halt_prog && a == 32'h0000_0010) return 32'h0000_0073;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous IMEM model: data valid the cycle after the strobe.
  always @(posedge clk) begin
    bus.ImemData <= bus.ImemReq ? imem_word(bus.ImemAddr) : 32'hDEAD_BEEF;
  end

  // Monitor: every accepted transfer must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.InstrValid && bus.InstrReady && !bus.Redirect) begin
      checks++;
      xfer_t.push_back($time);
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got pc=%h data=%h, required no transfer",
                 bus.InstrPC, bus.Instruction);
      end else begin
        e = sb_q.pop_front();
        if (bus.InstrPC !== e.pc || bus.Instruction !== e.data) begin
          errors++;
          $display("FAIL xfer: got pc=%h data=%h, required pc=%h data=%h",
                   bus.InstrPC, bus.Instruction, e.pc, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = imem_word(pc);
    sb_q.push_back(e);
  endtask

  // Accept instructions until every expected word has been seen (bounded).
  task automatic drain(input string name);
    int n;
    n = 0;
    bus.InstrReady = 1'b1;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = pc;
    @(posedge clk);
    #1;
    bus.Redirect   = 1'b0;
  endtask

  initial begin
    int reqs;
    checks         = 0;
    errors         = 0;
    halt_prog      = 1'b0;
    rst            = 1'b1;
    bus.InstrReady = 1'b1;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'h0000_0000;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.InstrValid}, 32'd0);
    chk("rst_req", {31'd0, bus.ImemReq}, 32'd0);
    chk("rst_halted", {31'd0, bus.Halted}, 32'd0);

    // Streaming from RESET_PC with InstrReady held high.
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    xfer_t.delete();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("idle_req", {31'd0, bus.ImemReq}, 32'd0);
    @(negedge clk); chk("first_req", {31'd0, bus.ImemReq}, 32'd1);
    chk("first_addr", bus.ImemAddr, 32'h0);
    @(negedge clk); chk("lat_valid_n3", {31'd0, bus.InstrValid}, 32'd0);
    @(negedge clk); chk("lat_valid_n4", {31'd0, bus.InstrValid}, 32'd1);
    drain("stream");
    if (xfer_t.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        chk("stream_gap", 32'(xfer_t[i] - xfer_t[i-1]), 32'd10);
      end
    end else begin
      chk("stream_count", 32'(xfer_t.size()), 32'd4);
    end

    // Reset mid-stream, then a 7-cycle decode stall from PC 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.InstrReady = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, bus.InstrValid}, 32'd0);
    chk("midrst_req", {31'd0, bus.ImemReq}, 32'd0);
    reqs = 0;
    repeat (7) begin
      @(negedge clk);
      reqs += int'(bus.ImemReq);
    end
    chk("stall_reqs", 32'(reqs), 32'd2);
    chk("stall_req_low", {31'd0, bus.ImemReq}, 32'd0);
    chk("stall_pc", bus.InstrPC, 32'h0);
    chk("stall_data", bus.Instruction, 32'hA5A5_0000);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    expect_pc(32'hC); expect_pc(32'h10);
    @(posedge clk); #1;
    drain("resume");

    // Redirect to 0x103 (low bits ignored) with the FIFO full; ready=1 in the
    // Redirect cycle must not consume a stale word.
    bus.InstrReady = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("full_req", {31'd0, bus.ImemReq}, 32'd0);
    chk("full_valid", {31'd0, bus.InstrValid}, 32'd1);
    @(posedge clk); #1;
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
    bus.InstrReady = 1'b1;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h0000_0103;
    @(negedge clk);
    chk("redir_cycle_req", {31'd0, bus.ImemReq}, 32'd0);
    @(posedge clk); #1;
    bus.Redirect = 1'b0;
    @(negedge clk);
    chk("redir_valid", {31'd0, bus.InstrValid}, 32'd0);
    chk("redir_req", {31'd0, bus.ImemReq}, 32'd1);
    chk("redir_addr", bus.ImemAddr, 32'h100);
    drain("redir");

    // Redirect mid-stream near the top of the address space: PC wraps.
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0); expect_pc(32'h4);
    redirect_to(32'hFFFF_FFF8);
    drain("wrap");
    bus.InstrReady = 1'b0;

    // Halt word at 0x10.
    halt_prog = 1'b1;
    expect_pc(32'h8); expect_pc(32'hC); expect_pc(32'h10);
    redirect_to(32'h8);
    drain("halt_prog");
    bus.InstrReady = 1'b0;
`ifdef FETCH_HALT_EN
    repeat (3) begin
      @(negedge clk);
      chk("halt_halted", {31'd0, bus.Halted}, 32'd1);
      chk("halt_valid", {31'd0, bus.InstrValid}, 32'd0);
      chk("halt_req", {31'd0, bus.ImemReq}, 32'd0);
    end
    @(posedge clk); #1;
    expect_pc(32'h40); expect_pc(32'h44);
    redirect_to(32'h40);
    @(negedge clk);
    chk("unhalt_halted", {31'd0, bus.Halted}, 32'd0);
    chk("unhalt_req", {31'd0, bus.ImemReq}, 32'd1);
    chk("unhalt_addr", bus.ImemAddr, 32'h40);
    drain("unhalt");
`else
    @(negedge clk);
    chk("nohalt_halted", {31'd0, bus.Halted}, 32'd0);
    chk("nohalt_valid", {31'd0, bus.InstrValid}, 32'd1);
    chk("nohalt_pc", bus.InstrPC, 32'h14);
    expect_pc(32'h14); expect_pc(32'h18);
    drain("nohalt");
`endif
    bus.InstrReady = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
